calc1_port_sequencer: RTL and testbench
=======================================

# calc1_port_sequencer

Shares one calc1 request port between four clients. Each client submits a complete operation (command plus both operands) with a single valid/ready handshake. The block arbitrates round-robin and sequences the two-cycle calc1 request protocol. It then waits for the calc1 response, with a timeout, and returns the result to the owning client. One operation is outstanding at a time; the block sits between client logic and one `reqN_cmd_in`/`reqN_data_in`/`out_respN`/`out_dataN` group of calc1.

## Interface
- `TIMEOUT_CYC`, default 16: maximum WAIT cycles before a timeout response (legal range 2–255).
- `c_clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cl_req_valid` in [0:3]: bit i is client i's request valid.
- `cl_req_cmd` in [0:15]: client i's command is bits [4i:4i+3].
- `cl_req_op1` in [0:127]: client i's first operand is bits [32i:32i+31].
- `cl_req_op2` in [0:127]: client i's second operand, same packing as op1.
- `cl_req_ready` out [0:3]: combinational, at most one bit high.
- `cl_rsp_valid` out [0:3]: one-hot, single-cycle response pulse to the owning client.
- `cl_rsp_code` out [0:1]: 1 = success, 2 = calc1 error or local reject, 3 = timeout.
- `cl_rsp_data` out [0:31]: result.
- `port_cmd_out` out [0:3]: to calc1 `reqN_cmd_in`.
- `port_data_out` out [0:31]: to calc1 `reqN_data_in`.
- `port_resp_in` in [0:1]: from calc1 `out_respN`.
- `port_data_in` in [0:31]: from calc1 `out_dataN`.
- `busy` out 1: high in every state except IDLE.
- `stray_cnt` out [0:7]: saturating count of responses that arrive outside WAIT.

## Operation
- Arbitration happens only in IDLE. The round-robin search starts at `last_grant+1` mod 4, and `last_grant` resets to 3 so client 0 has first priority.
- `cl_req_ready[g]` = IDLE && `cl_req_valid[g]` for the granted client g only. A transfer occurs when valid and ready are both high.
- On transfer the block latches cmd, op1, op2 and the owner index, and updates `last_grant`.
- FSM states:
  - IDLE: on transfer with cmd ≠ 0, go to SEND_CMD. On transfer with cmd = 0, go to RESP with code 2, data 0, and no port activity.
  - SEND_CMD: `port_cmd_out`=cmd, `port_data_out`=op1. Go to SEND_OP2.
  - SEND_OP2: `port_cmd_out`=0, `port_data_out`=op2. Go to WAIT and clear the timer.
  - WAIT: port outputs are 0. If `port_resp_in` ≠ 0, latch resp and `port_data_in` and go to RESP. Otherwise, once the timer reaches TIMEOUT_CYC, latch code 3 and data 0 and go to RESP.
  - RESP: `cl_rsp_valid[owner]`=1 with the latched code and data. Go to IDLE.
- `port_cmd_out` and `port_data_out` are registered and hold the values listed above for exactly the cycle the FSM occupies that state.
- Commands other than 0 are forwarded unmodified, including invalid codes. calc1's own code-2 response is passed through.
- `port_resp_in` ≠ 0 in any state other than WAIT is ignored for results and increments `stray_cnt`, which saturates at 255.
- Timer: 8 bits, cleared on entry to WAIT, incremented each WAIT cycle with no response. If a response and the timeout limit coincide in the same cycle, the response wins.

## Timing
- Reset values: state IDLE; `cl_req_ready`, `cl_rsp_valid`, `cl_rsp_code`, `cl_rsp_data`, `port_cmd_out`, `port_data_out`, `busy` and `stray_cnt` all 0; `last_grant` 3.
- With transfer at cycle T: SEND_CMD is T+1, SEND_OP2 is T+2, WAIT starts at T+3.
- A response seen in WAIT at cycle W gives `cl_rsp_valid` at W+1 and IDLE at W+2, so the next transfer can occur at W+2 at the earliest.
- A timeout gives RESP exactly TIMEOUT_CYC+1 cycles after WAIT entry.
- A cmd = 0 request gives RESP at T+1.
- A client may hold valid with changing data while not ready. Only the values present at the transfer edge are used.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values, and no `cl_rsp_valid` is issued for the aborted operation. calc1 must be reset separately by the system.

## Test plan
- Add: client0 cmd 1, op1 0x00000001, op2 0x1FFFFFFF; model returns resp 1, data 0x20000000 → port sees cmd1/0x00000001 then cmd0/0x1FFFFFFF, then `cl_rsp_valid`=4'b1000, code 1, data 0x20000000.
- Round robin: all four valid from reset release, model answers in 3 cycles → grant order 0,1,2,3,0; each response goes to the correct one-hot bit and `busy` drops only between operations.
- Overflow passthrough: client1 cmd 1, op1 0xFFFFFFFF, op2 0x00000001; model returns resp 2 → client1 gets code 2.
- Timeout: model never responds, TIMEOUT_CYC=16 → code 3, data 0, RESP 17 cycles after WAIT entry; an injected late resp 1 then gives `stray_cnt`=1 and no `cl_rsp_valid`.
- Local reject: client2 cmd 0 → code 2, data 0 at T+1; `port_cmd_out` stays 0 throughout.
- Reset in WAIT: assert `reset` for 1 cycle → all outputs 0 the next cycle, no response pulse; the next request from clients 0 and 3 grants client 0 first.

Source files
------------

// File: rtl/calc1_port_sequencer_if.sv
// Client-side and calc1-side signal bundle for calc1_port_sequencer.
// The sequencer connects through the slave modport; client/port logic uses master.
interface calc1_port_sequencer_if;
    logic [0:3]   cl_req_valid;
    logic [0:15]  cl_req_cmd;
    logic [0:127] cl_req_op1;
    logic [0:127] cl_req_op2;
    logic [0:3]   cl_req_ready;
    logic [0:3]   cl_rsp_valid;
    logic [0:1]   cl_rsp_code;
    logic [0:31]  cl_rsp_data;
    logic [0:3]   port_cmd_out;
    logic [0:31]  port_data_out;
    logic [0:1]   port_resp_in;
    logic [0:31]  port_data_in;
    logic         busy;
    logic [0:7]   stray_cnt;
    logic [2:0]   state_dbg;

    // Request handshake: a transfer happens on a rising edge where
    // cl_req_valid[i] and cl_req_ready[i] are both high; ready never
    // depends on anything but FSM state, valid bits and last grant.
    modport slave (
        input  cl_req_valid, cl_req_cmd, cl_req_op1, cl_req_op2,
        input  port_resp_in, port_data_in,
        output cl_req_ready, cl_rsp_valid, cl_rsp_code, cl_rsp_data,
        output port_cmd_out, port_data_out, busy, stray_cnt, state_dbg
    );

    modport master (
        output cl_req_valid, cl_req_cmd, cl_req_op1, cl_req_op2,
        output port_resp_in, port_data_in,
        input  cl_req_ready, cl_rsp_valid, cl_rsp_code, cl_rsp_data,
        input  port_cmd_out, port_data_out, busy, stray_cnt, state_dbg
    );
endinterface

// File: rtl/calc1_port_sequencer.sv
// Round-robin share of one calc1 request port between four clients, one
// operation outstanding, with response timeout and stray-response counting.
module calc1_port_sequencer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     c_clk,
    input  logic                     reset,
    calc1_port_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_CMD = 3'd1,
        S_SEND_OP2 = 3'd2,
        S_WAIT     = 3'd3,
        S_RESP     = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  owner_q, owner_d;
    logic [31:0] op2_q, op2_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  stray_q, stray_d;
    logic [3:0]  port_cmd_q, port_cmd_d;
    logic [31:0] port_data_q, port_data_d;
    logic [0:3]  rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_code_q, rsp_code_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        grant_found;
    logic [1:0]  grant;
    logic [3:0]  sel_cmd;
    logic [31:0] sel_op1;
    logic [31:0] sel_op2;
    logic [0:3]  ready_vec;
    logic        transfer;

    // Search starts one past the last grant; offset 4 wraps back onto it.
    always_comb begin
        grant_found = 1'b0;
        grant       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!grant_found && bus.cl_req_valid[last_grant_q + 2'(k)]) begin
                grant_found = 1'b1;
                grant       = last_grant_q + 2'(k);
            end
        end
    end

    always_comb begin
        sel_cmd = 4'd0;
        sel_op1 = 32'd0;
        sel_op2 = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant == 2'(i)) begin
                sel_cmd = bus.cl_req_cmd[4*i +: 4];
                sel_op1 = bus.cl_req_op1[32*i +: 32];
                sel_op2 = bus.cl_req_op2[32*i +: 32];
            end
        end
    end

    assign transfer = (state_q == S_IDLE) && grant_found && !reset;

    always_comb begin
        ready_vec = '0;
        if (transfer) ready_vec[grant] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op2_d        = op2_q;
        timer_d      = timer_q;
        port_cmd_d   = 4'd0;
        port_data_d  = 32'd0;
        rsp_valid_d  = '0;
        rsp_code_d   = 2'd0;
        rsp_data_d   = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    op2_d        = sel_op2;
                    if (sel_cmd != 4'd0) begin
                        state_d     = S_SEND_CMD;
                        port_cmd_d  = sel_cmd;
                        port_data_d = sel_op1;
                    end else begin
                        // cmd 0 never reaches calc1; reject locally.
                        state_d            = S_RESP;
                        rsp_valid_d[grant] = 1'b1;
                        rsp_code_d         = 2'd2;
                    end
                end
            end
            S_SEND_CMD: begin
                state_d     = S_SEND_OP2;
                port_data_d = op2_q;
            end
            S_SEND_OP2: begin
                state_d = S_WAIT;
                timer_d = 8'd0;
            end
            S_WAIT: begin
                // A response arriving on the timeout cycle still wins.
                if (bus.port_resp_in != 2'd0) begin
                    state_d              = S_RESP;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_code_d           = bus.port_resp_in;
                    rsp_data_d           = bus.port_data_in;
                end else if (timer_q == 8'(TIMEOUT_CYC)) begin
                    state_d              = S_RESP;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_code_d           = 2'd3;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stray_d = stray_q;
        if (bus.port_resp_in != 2'd0 && state_q != S_WAIT && stray_q != 8'hFF)
            stray_d = stray_q + 8'd1;
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 2'd3;
            owner_q      <= 2'd0;
            op2_q        <= 32'd0;
            timer_q      <= 8'd0;
            stray_q      <= 8'd0;
            port_cmd_q   <= 4'd0;
            port_data_q  <= 32'd0;
            rsp_valid_q  <= '0;
            rsp_code_q   <= 2'd0;
            rsp_data_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op2_q        <= op2_d;
            timer_q      <= timer_d;
            stray_q      <= stray_d;
            port_cmd_q   <= port_cmd_d;
            port_data_q  <= port_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_code_q   <= rsp_code_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign bus.cl_req_ready  = ready_vec;
    assign bus.cl_rsp_valid  = rsp_valid_q;
    assign bus.cl_rsp_code   = rsp_code_q;
    assign bus.cl_rsp_data   = rsp_data_q;
    assign bus.port_cmd_out  = port_cmd_q;
    assign bus.port_data_out = port_data_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.stray_cnt     = stray_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_calc1_port_sequencer.sv
// Directed plus randomized bench for calc1_port_sequencer; a transaction-level
// model predicts grant order, port sequence and client responses.
module tb_calc1_port_sequencer;
    localparam int TMO = 16;

    logic c_clk = 1'b0;
    logic reset = 1'b1;
    calc1_port_sequencer_if bus();

    calc1_port_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 c_clk = ~c_clk;

    int n_vec = 0;
    int n_err = 0;
    int last_m = 3;
    bit          v_a   [4];
    logic [3:0]  cmd_a [4];
    logic [31:0] op1_a [4];
    logic [31:0] op2_a [4];

    task automatic tick();
        @(posedge c_clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int g);
        return 4'(4'b1000 >> g);
    endfunction

    // Round robin: first valid client after the last one served.
    function automatic int rr_pick();
        for (int k = 1; k <= 4; k++)
            if (v_a[(last_m + k) % 4]) return (last_m + k) % 4;
        return -1;
    endfunction

    task automatic drive_clients();
        for (int i = 0; i < 4; i++) begin
            bus.cl_req_valid[i]          = v_a[i];
            bus.cl_req_cmd[4*i +: 4]     = cmd_a[i];
            bus.cl_req_op1[32*i +: 32]   = op1_a[i];
            bus.cl_req_op2[32*i +: 32]   = op2_a[i];
        end
    endtask

    task automatic set_client(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        v_a[i] = 1'b1; cmd_a[i] = c; op1_a[i] = a; op2_a[i] = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.cl_rsp_valid), 32'd0);
        check({tag, "_rsp_code"},  32'(bus.cl_rsp_code), 32'd0);
        check({tag, "_rsp_data"},  bus.cl_rsp_data, 32'd0);
        check({tag, "_port_cmd"},  32'(bus.port_cmd_out), 32'd0);
        check({tag, "_port_data"}, bus.port_data_out, 32'd0);
        check({tag, "_busy"},      32'(bus.busy), 32'd0);
        check({tag, "_ready"},     32'(bus.cl_req_ready), 32'd0);
    endtask

    // One full operation: lat < 0 means calc1 never answers.
    task automatic do_op(input int lat, input logic [1:0] cresp, input logic [31:0] cdata,
                         input bit drop, input bit scramble);
        int g;
        int n;
        logic [3:0]  c;
        logic [31:0] a, b, exp_data;
        logic [1:0]  exp_code;
        g = rr_pick();
        n = 0;
        #1;
        while (bus.cl_req_ready == 4'd0 && n < 20) begin
            tick(); #1; n++;
        end
        check("grant", 32'(bus.cl_req_ready), 32'(onehot(g)));
        c = cmd_a[g]; a = op1_a[g]; b = op2_a[g];
        last_m = g;
        tick();
        if (drop) v_a[g] = 1'b0;
        if (scramble)
            for (int j = 0; j < 4; j++)
                if (j != g && v_a[j]) begin
                    cmd_a[j] = 4'($urandom_range(0, 15));
                    op1_a[j] = $urandom; op2_a[j] = $urandom;
                end
        drive_clients();
        if (c == 4'd0) begin
            check("rej_valid", 32'(bus.cl_rsp_valid), 32'(onehot(g)));
            check("rej_code",  32'(bus.cl_rsp_code), 32'd2);
            check("rej_data",  bus.cl_rsp_data, 32'd0);
            check("rej_port",  32'(bus.port_cmd_out), 32'd0);
            tick();
            check("rej_port2", 32'(bus.port_cmd_out), 32'd0);
            check("rej_busy",  32'(bus.busy), 32'd0);
            return;
        end
        check("send_cmd",  32'(bus.port_cmd_out), 32'(c));
        check("send_op1",  bus.port_data_out, a);
        check("send_busy", 32'(bus.busy), 32'd1);
        tick();
        check("op2_cmd", 32'(bus.port_cmd_out), 32'd0);
        check("op2_data", bus.port_data_out, b);
        tick();
        check("wait_cmd",  32'(bus.port_cmd_out), 32'd0);
        check("wait_data", bus.port_data_out, 32'd0);
        if (lat >= 0) begin
            repeat (lat) tick();
            bus.port_resp_in = cresp;
            bus.port_data_in = cdata;
            tick();
            bus.port_resp_in = 2'd0;
            bus.port_data_in = $urandom;
            exp_code = cresp; exp_data = cdata;
        end else begin
            n = 0;
            while (bus.cl_rsp_valid == 4'd0 && n < 300) begin
                tick(); n++;
            end
            check("tmo_latency", 32'(n), 32'(TMO + 1));
            exp_code = 2'd3; exp_data = 32'd0;
        end
        check("rsp_valid", 32'(bus.cl_rsp_valid), 32'(onehot(g)));
        check("rsp_code",  32'(bus.cl_rsp_code), 32'(exp_code));
        check("rsp_data",  bus.cl_rsp_data, exp_data);
        check("rsp_busy",  32'(bus.busy), 32'd1);
        tick();
        check("end_busy",  32'(bus.busy), 32'd0);
        check("end_valid", 32'(bus.cl_rsp_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 4; i++) begin
            v_a[i] = 1'b0; cmd_a[i] = 4'd0; op1_a[i] = 32'd0; op2_a[i] = 32'd0;
        end
        drive_clients();
        bus.port_resp_in = 2'd0;
        bus.port_data_in = 32'd0;

        // Reset state
        repeat (3) tick();
        check_idle_outputs("reset");
        check("reset_stray", 32'(bus.stray_cnt), 32'd0);

        // Round robin with all four valid from reset release
        for (int i = 0; i < 4; i++) set_client(i, 4'(i + 1), $urandom, $urandom);
        drive_clients();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("rr_order_model", 32'(rr_pick()), 32'(k % 4));
            do_op(3, 2'd1, op1_a[k % 4] + op2_a[k % 4], 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) v_a[i] = 1'b0;
        drive_clients();
        tick();

        // Add
        set_client(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
        drive_clients();
        do_op(2, 2'd1, 32'h2000_0000, 1'b1, 1'b0);

        // Overflow passthrough of calc1 error code
        set_client(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        drive_clients();
        do_op(1, 2'd2, 32'h0000_0000, 1'b1, 1'b0);

        // Response on the timeout cycle wins
        set_client(2, 4'd2, 32'h1234_5678, 32'h0000_0010);
        drive_clients();
        do_op(TMO, 2'd1, 32'hCAFE_F00D, 1'b1, 1'b0);

        // Timeout then a late stray response
        set_client(3, 4'd5, 32'hDEAD_BEEF, 32'h0000_0003);
        drive_clients();
        do_op(-1, 2'd0, 32'd0, 1'b1, 1'b0);
        bus.port_resp_in = 2'd1;
        tick();
        bus.port_resp_in = 2'd0;
        check("stray_one", 32'(bus.stray_cnt), 32'd1);
        check("stray_no_rsp", 32'(bus.cl_rsp_valid), 32'd0);
        tick();
        check("stray_no_rsp2", 32'(bus.cl_rsp_valid), 32'd0);

        // Local reject
        set_client(2, 4'd0, $urandom, $urandom);
        drive_clients();
        do_op(0, 2'd1, 32'd0, 1'b1, 1'b0);

        // Stray counter saturation
        bus.port_resp_in = 2'd2;
        repeat (260) tick();
        bus.port_resp_in = 2'd0;
        tick();
        check("stray_sat", 32'(bus.stray_cnt), 32'd255);

        // Reset while in WAIT
        set_client(2, 4'd3, $urandom, $urandom);
        drive_clients();
        #1;
        check("rw_grant", 32'(bus.cl_req_ready), 32'(onehot(rr_pick())));
        tick();
        v_a[2] = 1'b0;
        drive_clients();
        tick();
        tick();
        check("rw_in_wait", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_m = 3;
        check_idle_outputs("rw");
        check("rw_stray", 32'(bus.stray_cnt), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rw_no_rsp", 32'(bus.cl_rsp_valid), 32'd0);
        end
        set_client(3, 4'd1, $urandom, $urandom);
        set_client(0, 4'd1, $urandom, $urandom);
        drive_clients();
        check("rw_model_first", 32'(rr_pick()), 32'd0);
        do_op(2, 2'd1, $urandom, 1'b1, 1'b0);
        do_op(2, 2'd1, $urandom, 1'b1, 1'b0);

        // Randomized operations with scrambled waiting clients
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 4; i++)
                if (!v_a[i] && $urandom_range(0, 1) == 1)
                    set_client(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
            if (rr_pick() < 0)
                set_client(int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom, $urandom);
            drive_clients();
            lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO));
            do_op(lat, 2'($urandom_range(1, 2)), $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end
        check("rand_stray", 32'(bus.stray_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
